// File: rtl/sum_block_accum.sv
// sum_block_accum: accumulates blocks of 2^LOG2_LEN samples. It produces a registered block sum
// and a registered block mean, and pulses sum_enable for one cycle when both are updated.
//
// Ports:
//   CLK         rising-edge system clock
//   RST         asynchronous active-high reset
//   input_data  sample, DATA_W bits (unsigned or two's complement per SIGNED_MODE)
//   data_valid  input_data is valid this cycle
//   data_start  first sample of a block; in ACCUM it discards the partial block
//   sum         registered block sum, DATA_W+LOG2_LEN bits
//   avg         registered block mean (sum shifted right by LOG2_LEN)
//   sum_enable  one-cycle pulse: sum/avg newly updated
//   busy        high while accumulating
//   restart     one-cycle pulse: a partial block was discarded
module sum_block_accum #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LOG2_LEN    = 8,
  parameter bit          SIGNED_MODE = 1'b0,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_W-1:0]            input_data,
  input  logic                         data_valid,
  input  logic                         data_start,
  output logic [DATA_W+LOG2_LEN-1:0]   sum,
  output logic [DATA_W-1:0]            avg,
  output logic                         sum_enable,
  output logic                         busy,
  output logic                         restart
);

  localparam int unsigned SUM_W = DATA_W + LOG2_LEN;

  typedef logic [SUM_W-1:0]    acc_t;
  typedef logic [LOG2_LEN-1:0] cnt_t;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e            state_q, state_d;
  acc_t              acc_q, acc_d;
  cnt_t              cnt_q, cnt_d;
  acc_t              sum_q, sum_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              sum_en_q, sum_en_d;
  logic              restart_q, restart_d;

  logic ext_bit;
  acc_t sample_ext;
  acc_t acc_plus;

  // The LOG2_LEN guard bits of SUM_W absorb the growth of 2^LOG2_LEN samples, so no overflow.
  always_comb begin
    ext_bit    = SIGNED_MODE & input_data[DATA_W-1];
    sample_ext = {{LOG2_LEN{ext_bit}}, input_data};
    acc_plus   = acc_q + sample_ext;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    sum_en_d  = 1'b0;
    restart_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_start) begin
          state_d = StAccum;
          acc_d   = data_valid ? sample_ext : '0;
          cnt_d   = data_valid ? cnt_t'(1) : '0;
        end
      end
      StAccum: begin
        // data_start wins over completion: the current sample opens the new block.
        if (data_start) begin
          restart_d = 1'b1;
          acc_d     = data_valid ? sample_ext : '0;
          cnt_d     = data_valid ? cnt_t'(1) : '0;
        end else if (data_valid) begin
          if (&cnt_q) begin
            // Taking the upper bits of the sum is an arithmetic shift in signed mode (floor).
            sum_d    = acc_plus;
            avg_d    = acc_plus[SUM_W-1:LOG2_LEN];
            sum_en_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            if (!CONTINUOUS) begin
              state_d = StIdle;
            end
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
      sum_en_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      sum_en_q  <= sum_en_d;
      restart_q <= restart_d;
    end
  end

  assign sum        = sum_q;
  assign avg        = avg_q;
  assign sum_enable = sum_en_q;
  assign busy       = (state_q == StAccum);
  assign restart    = restart_q;

endmodule

// File: tb/tb_sum_block_accum.sv
// Bench for sum_block_accum. Three instances share one stimulus stream: unsigned single-block,
// signed single-block, and unsigned continuous. A monitor on the falling edge watches the
// selected instance and pops expected results from a scoreboard on every sum_enable.
module tb_sum_block_accum;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] input_data;
  logic       data_valid;
  logic       data_start;

  logic [15:0] sum_a  [3];
  logic [7:0]  avg_a  [3];
  logic        en_a   [3];
  logic        busy_a [3];
  logic        rs_a   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sum_block_accum #(
      .DATA_W     (8),
      .LOG2_LEN   (8),
      .SIGNED_MODE(g == 1),
      .CONTINUOUS (g == 2)
    ) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .input_data(input_data),
      .data_valid(data_valid),
      .data_start(data_start),
      .sum       (sum_a[g]),
      .avg       (avg_a[g]),
      .sum_enable(en_a[g]),
      .busy      (busy_a[g]),
      .restart   (rs_a[g])
    );
  end

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int sel = 0;
  logic [15:0] m_sum;
  logic [7:0]  m_avg;
  logic        m_en, m_busy, m_restart;
  always_comb begin
    m_sum     = sum_a[sel];
    m_avg     = avg_a[sel];
    m_en      = en_a[sel];
    m_busy    = busy_a[sel];
    m_restart = rs_a[sel];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic [7:0]  a;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   restarts = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (m_en) begin
        check("en_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sum", m_sum, mon_e.s);
          check("avg", m_avg, mon_e.a);
          check("latency_cycle", cyc, mon_e.c);
        end
      end
      if (m_restart) begin
        restarts++;
        check("restart_excl_en", m_en, 0);
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic s);
    @(posedge CLK);
    #1;
    input_data = d;
    data_valid = v;
    data_start = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    idle(3);
    check(tag, sb.size(), 0);
  endtask

  // One 256-sample block: ramp 0..255 or a constant, optionally with an idle cycle after each.
  task automatic block(input logic [7:0] base, input bit ramp, input bit gaps,
                       input logic [15:0] exp_sum, input logic [7:0] exp_avg);
    for (int i = 0; i < 256; i++) begin
      drive(ramp ? 8'(i) : base, 1'b1, i == 0);
      if (i == 255) sb.push_back('{exp_sum, exp_avg, cyc + 1});
      if (i == 10) begin
        @(negedge CLK);
        check("busy_mid_block", m_busy, 1);
      end
      if (gaps) drive(8'hAA, 1'b0, 1'b0);
    end
    drain("block_drain");
    check("busy_after_block", m_busy, 0);
  endtask

  int r0;

  initial begin
    input_data = '0;
    data_valid = 1'b0;
    data_start = 1'b0;

    #2 RST = 1'b1;
    #2;
    for (int g = 0; g < 3; g++) begin
      check("rst_sum", sum_a[g], 0);
      check("rst_avg", avg_a[g], 0);
      check("rst_en", en_a[g], 0);
      check("rst_busy", busy_a[g], 0);
      check("rst_restart", rs_a[g], 0);
    end
    @(posedge CLK);
    #1 RST = 1'b0;

    // Unsigned single-block instance.
    sel = 0;
    block(8'h00, 1'b1, 1'b0, 16'h7F80, 8'h7F);
    block(8'hFF, 1'b0, 1'b0, 16'hFF00, 8'hFF);

    // Signed instance.
    sel = 1;
    block(8'h80, 1'b0, 1'b0, 16'h8000, 8'h80);
    block(8'hFF, 1'b0, 1'b0, 16'hFF00, 8'hFF);

    // Unsigned, valid only on alternate cycles.
    sel = 0;
    block(8'h00, 1'b1, 1'b1, 16'h7F80, 8'h7F);

    // Abort at sample 100 then a full ramp.
    r0 = restarts;
    for (int i = 0; i < 100; i++) drive(8'(i), 1'b1, i == 0);
    block(8'h00, 1'b1, 1'b0, 16'h7F80, 8'h7F);
    check("abort_restart_count", restarts - r0, 1);

    // data_start on the 256th sample beats completion.
    r0 = restarts;
    for (int i = 0; i < 256; i++) drive(8'(i), 1'b1, (i == 0) || (i == 255));
    drain("start_on_last_drain");
    check("start_on_last_restart", restarts - r0, 1);
    check("sum_held", m_sum, 16'h7F80);
    check("avg_held", m_avg, 8'h7F);

    // Continuous instance.
    sel = 2;
    @(posedge CLK);
    #3 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    r0 = restarts;
    for (int i = 0; i < 768; i++) begin
      drive(8'(i), 1'b1, i == 0);
      if ((i % 256) == 255) sb.push_back('{16'h7F80, 8'h7F, cyc + 1});
    end
    for (int i = 0; i < 100; i++) drive(8'(i), 1'b1, 1'b0);
    check("cont_pending", sb.size(), 0);

    // Asynchronous reset mid-block, away from any clock edge.
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("midrst_sum", m_sum, 0);
    check("midrst_avg", m_avg, 0);
    check("midrst_en", m_en, 0);
    check("midrst_busy", m_busy, 0);
    check("midrst_restart", m_restart, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 5; i++) drive(8'(i + 1), 1'b1, 1'b0);
    @(negedge CLK);
    check("post_rst_idle_busy", m_busy, 0);
    check("post_rst_sum", m_sum, 0);
    drain("post_rst_drain");
    check("post_rst_no_restart", restarts - r0, 0);
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b0);
    @(negedge CLK);
    check("post_rst_start_busy", m_busy, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
